// File: rtl/dwise_seq_pkg.sv
// Shared types and helpers for the depthwise sliding-window sequencer.
package dwise_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned KERNEL_SIZE_DEF = 3;

  function automatic int unsigned tap_count(input int unsigned k);
    return k * k;
  endfunction

  // Output edge of a square map; zero when the padded map is smaller than the kernel.
  function automatic int out_size(input int i_size, input int pad, input int k, input int stride);
    int span;
    span = i_size + 2 * pad - k;
    if (span < 0) return 0;
    return span / stride + 1;
  endfunction

endpackage

// File: rtl/dwise_tap_addr.sv
// One kernel tap: maps the current output position to an NHWC address and in-bounds flag.
module dwise_tap_addr #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned STRIDE_WIDTH = 2,
  parameter int unsigned PAD_WIDTH    = 2,
  parameter int unsigned KX           = 0,
  parameter int unsigned KY           = 0
) (
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH-1:0]   i_size,
  input  logic [ADDR_WIDTH-1:0]   c_size,
  input  logic [STRIDE_WIDTH-1:0] stride,
  input  logic [PAD_WIDTH-1:0]    pad,
  input  logic [CNT_WIDTH-1:0]    pos_x,
  input  logic [CNT_WIDTH-1:0]    pos_y,
  input  logic [ADDR_WIDTH-1:0]   chan,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    in_bound
);

  localparam int unsigned CDW = CNT_WIDTH + STRIDE_WIDTH + 8;

  logic signed [CDW-1:0]  ix;
  logic signed [CDW-1:0]  iy;
  logic                   in_x;
  logic                   in_y;
  logic [ADDR_WIDTH-1:0]  ixa;
  logic [ADDR_WIDTH-1:0]  iya;
  logic [ADDR_WIDTH-1:0]  lin;
  logic [ADDR_WIDTH-1:0]  raw;

  // Address arithmetic is modular, so low bits of the coordinates suffice.
  always_comb begin
    ix   = $signed(CDW'(pos_x) * CDW'(stride)) - $signed(CDW'(pad)) + $signed(CDW'(KX));
    iy   = $signed(CDW'(pos_y) * CDW'(stride)) - $signed(CDW'(pad)) + $signed(CDW'(KY));
    in_x = !ix[CDW-1] && (ix[CDW-2:0] < (CDW-1)'(i_size));
    in_y = !iy[CDW-1] && (iy[CDW-2:0] < (CDW-1)'(i_size));
    in_bound = in_x && in_y;
    ixa  = ix[ADDR_WIDTH-1:0];
    iya  = iy[ADDR_WIDTH-1:0];
    lin  = ixa * i_size + iya;
    raw  = start_addr + lin * c_size + chan;
    addr = in_bound ? raw : '0;
  end

endmodule

// File: rtl/dwise_window_seq.sv
// Walks channels and output positions of one layer, emitting one K*K window per accepted beat.
module dwise_window_seq
  import dwise_seq_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned KERNEL_SIZE  = KERNEL_SIZE_DEF,
  parameter int unsigned STRIDE_WIDTH = 2,
  parameter int unsigned PAD_WIDTH    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_start_addr,
  input  logic [ADDR_WIDTH-1:0]   i_i_size,
  input  logic [ADDR_WIDTH-1:0]   i_i_c_size,
  input  logic [STRIDE_WIDTH-1:0] i_stride,
  input  logic [PAD_WIDTH-1:0]    i_pad,
  input  logic [ROWS-1:0]         i_row_id,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [0:KERNEL_SIZE*KERNEL_SIZE-1][ADDR_WIDTH-1:0] o_addr,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0] o_mask,
  output logic [ADDR_WIDTH-1:0]   o_o_x,
  output logic [ADDR_WIDTH-1:0]   o_o_y,
  output logic [ADDR_WIDTH-1:0]   o_c,
  output logic [ROWS-1:0]         o_row_id,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned ADDR_LENGTH = tap_count(KERNEL_SIZE);
  localparam int unsigned CW          = ADDR_WIDTH + 2;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0]   cfg_start, cfg_start_n, cfg_i, cfg_i_n, cfg_c, cfg_c_n;
  logic [STRIDE_WIDTH-1:0] cfg_s, cfg_s_n;
  logic [PAD_WIDTH-1:0]    cfg_p, cfg_p_n;
  logic [ROWS-1:0]         cfg_row, cfg_row_n;
  logic [CW-1:0]           cfg_osz, cfg_osz_n;
  logic [CW-1:0]           cx, cx_n, cy, cy_n;
  logic [ADDR_WIDTH-1:0]   cc, cc_n;

  logic                    valid_n, busy_n, done_n;
  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] addr_n;
  logic [ADDR_LENGTH-1:0]  mask_n;
  logic [ADDR_WIDTH-1:0]   ox_n, oy_n, oc_n;
  logic [ROWS-1:0]         row_n;

  logic [ADDR_WIDTH-1:0]   start_sel, i_sel, c_sel;
  logic [STRIDE_WIDTH-1:0] s_sel, s_in;
  logic [PAD_WIDTH-1:0]    p_sel;
  logic [ROWS-1:0]         row_sel;
  logic [CW-1:0]           osz_in, osz_sel;
  logic                    empty_sel, last, load;

  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] tap_addr;
  logic [ADDR_LENGTH-1:0]  tap_in;

  // In IDLE the taps see live inputs so the first window loads on the start edge.
  always_comb begin
    s_in      = (i_stride == '0) ? STRIDE_WIDTH'(1) : i_stride;
    osz_in    = CW'(out_size(int'(i_i_size), int'(i_pad), int'(KERNEL_SIZE), int'(s_in)));
    start_sel = (state == IDLE) ? i_start_addr : cfg_start;
    i_sel     = (state == IDLE) ? i_i_size     : cfg_i;
    c_sel     = (state == IDLE) ? i_i_c_size   : cfg_c;
    s_sel     = (state == IDLE) ? s_in         : cfg_s;
    p_sel     = (state == IDLE) ? i_pad        : cfg_p;
    row_sel   = (state == IDLE) ? i_row_id     : cfg_row;
    osz_sel   = (state == IDLE) ? osz_in       : cfg_osz;
    empty_sel = (osz_sel == '0) || (c_sel == '0);
    last      = (cc == c_sel - ADDR_WIDTH'(1)) && (cx == osz_sel - CW'(1)) &&
                (cy == osz_sel - CW'(1));
  end

  for (genvar kx = 0; kx < KERNEL_SIZE; kx++) begin : g_kx
    for (genvar ky = 0; ky < KERNEL_SIZE; ky++) begin : g_ky
      dwise_tap_addr #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .CNT_WIDTH   (CW),
        .STRIDE_WIDTH(STRIDE_WIDTH),
        .PAD_WIDTH   (PAD_WIDTH),
        .KX          (kx),
        .KY          (ky)
      ) u_tap (
        .start_addr(start_sel),
        .i_size    (i_sel),
        .c_size    (c_sel),
        .stride    (s_sel),
        .pad       (p_sel),
        .pos_x     (cx),
        .pos_y     (cy),
        .chan      (cc),
        .addr      (tap_addr[kx*KERNEL_SIZE+ky]),
        .in_bound  (tap_in[kx*KERNEL_SIZE+ky])
      );
    end
  end

  // Next-state, counter walk and output register load.
  always_comb begin
    state_n     = state;
    cfg_start_n = cfg_start;
    cfg_i_n     = cfg_i;
    cfg_c_n     = cfg_c;
    cfg_s_n     = cfg_s;
    cfg_p_n     = cfg_p;
    cfg_row_n   = cfg_row;
    cfg_osz_n   = cfg_osz;
    cx_n        = cx;
    cy_n        = cy;
    cc_n        = cc;
    valid_n     = o_valid;
    addr_n      = o_addr;
    mask_n      = o_mask;
    ox_n        = o_o_x;
    oy_n        = o_o_y;
    oc_n        = o_c;
    row_n       = o_row_id;
    done_n      = 1'b0;
    load        = 1'b0;

    if (i_clear) begin
      state_n = IDLE;
      cx_n    = '0;
      cy_n    = '0;
      cc_n    = '0;
      valid_n = 1'b0;
      addr_n  = '0;
      mask_n  = '0;
      ox_n    = '0;
      oy_n    = '0;
      oc_n    = '0;
      row_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            cfg_start_n = i_start_addr;
            cfg_i_n     = i_i_size;
            cfg_c_n     = i_i_c_size;
            cfg_s_n     = s_in;
            cfg_p_n     = i_pad;
            cfg_row_n   = i_row_id;
            cfg_osz_n   = osz_in;
            if (empty_sel) done_n = 1'b1;
            else           load   = 1'b1;
          end
        end
        RUN: begin
          if (!o_valid || i_ready) load = 1'b1;
        end
        DRAIN: begin
          if (i_ready) begin
            state_n = IDLE;
            valid_n = 1'b0;
            done_n  = 1'b1;
            addr_n  = '0;
            mask_n  = '0;
            ox_n    = '0;
            oy_n    = '0;
            oc_n    = '0;
            row_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase

      if (load) begin
        valid_n = 1'b1;
        addr_n  = tap_addr;
        mask_n  = tap_in;
        ox_n    = ADDR_WIDTH'(cx);
        oy_n    = ADDR_WIDTH'(cy);
        oc_n    = cc;
        row_n   = row_sel;
        if (last) begin
          state_n = DRAIN;
          cx_n    = '0;
          cy_n    = '0;
          cc_n    = '0;
        end else begin
          state_n = RUN;
          // o_y innermost, then o_x, then channel.
          if (cy == osz_sel - CW'(1)) begin
            cy_n = '0;
            if (cx == osz_sel - CW'(1)) begin
              cx_n = '0;
              cc_n = cc + ADDR_WIDTH'(1);
            end else begin
              cx_n = cx + CW'(1);
            end
          end else begin
            cy_n = cy + CW'(1);
          end
        end
      end
    end

    busy_n = (state_n == RUN) || valid_n;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cfg_start <= '0;
      cfg_i     <= '0;
      cfg_c     <= '0;
      cfg_s     <= '0;
      cfg_p     <= '0;
      cfg_row   <= '0;
      cfg_osz   <= '0;
      cx        <= '0;
      cy        <= '0;
      cc        <= '0;
      o_valid   <= 1'b0;
      o_addr    <= '0;
      o_mask    <= '0;
      o_o_x     <= '0;
      o_o_y     <= '0;
      o_c       <= '0;
      o_row_id  <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_n;
      cfg_start <= cfg_start_n;
      cfg_i     <= cfg_i_n;
      cfg_c     <= cfg_c_n;
      cfg_s     <= cfg_s_n;
      cfg_p     <= cfg_p_n;
      cfg_row   <= cfg_row_n;
      cfg_osz   <= cfg_osz_n;
      cx        <= cx_n;
      cy        <= cy_n;
      cc        <= cc_n;
      o_valid   <= valid_n;
      o_addr    <= addr_n;
      o_mask    <= mask_n;
      o_o_x     <= ox_n;
      o_o_y     <= oy_n;
      o_c       <= oc_n;
      o_row_id  <= row_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
    end
  end

endmodule

// File: tb/tb_dwise_window_seq.sv
// Scoreboard bench for dwise_window_seq: reference windows queued at start, monitor pops on accept.
module tb_dwise_window_seq;

  localparam int ROWS = 4;
  localparam int AW   = 6;
  localparam int K    = 3;
  localparam int TAPS = K * K;

  typedef struct {
    logic [0:TAPS-1][AW-1:0] addr;
    logic [TAPS-1:0]         mask;
    logic [AW-1:0]           ox;
    logic [AW-1:0]           oy;
    logic [AW-1:0]           c;
    logic [ROWS-1:0]         row;
  } win_t;

  logic clk = 1'b0;
  logic i_rst, i_clear, i_start, i_ready;
  logic [AW-1:0] i_start_addr, i_i_size, i_i_c_size;
  logic [1:0] i_stride, i_pad;
  logic [ROWS-1:0] i_row_id;
  logic o_valid, o_busy, o_done;
  logic [0:TAPS-1][AW-1:0] o_addr;
  logic [TAPS-1:0] o_mask;
  logic [AW-1:0] o_o_x, o_o_y, o_c;
  logic [ROWS-1:0] o_row_id;

  win_t exp_q[$];
  win_t mon_w;
  int n_chk = 0;
  int n_pass = 0;
  int done_seen = 0;
  bit done_pending = 1'b0;
  bit stall_prev = 1'b0;
  int ready_mode = 0;
  logic [127:0] held;

  dwise_window_seq dut (
    .i_clk(clk), .i_rst(i_rst), .i_clear(i_clear), .i_start(i_start),
    .i_start_addr(i_start_addr), .i_i_size(i_i_size), .i_i_c_size(i_i_c_size),
    .i_stride(i_stride), .i_pad(i_pad), .i_row_id(i_row_id), .i_ready(i_ready),
    .o_valid(o_valid), .o_addr(o_addr), .o_mask(o_mask), .o_o_x(o_o_x),
    .o_o_y(o_o_y), .o_c(o_c), .o_row_id(o_row_id), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Reference: enumerate windows straight from the coordinate/address rules.
  task automatic model(input int st, input int ii, input int cc, input int ss, input int pp,
                       input logic [ROWS-1:0] row, output int n);
    int s, o, span, ix, iy, t;
    win_t w;
    n = 0;
    s = (ss == 0) ? 1 : ss;
    span = ii + 2 * pp - K;
    o = (span < 0) ? 0 : span / s + 1;
    if (o == 0 || cc == 0) return;
    for (int ch = 0; ch < cc; ch++)
      for (int x = 0; x < o; x++)
        for (int y = 0; y < o; y++) begin
          for (int kx = 0; kx < K; kx++)
            for (int ky = 0; ky < K; ky++) begin
              ix = x * s - pp + kx;
              iy = y * s - pp + ky;
              t = kx * K + ky;
              if (ix >= 0 && ix < ii && iy >= 0 && iy < ii) begin
                w.addr[t] = AW'(st + (ix * ii + iy) * cc + ch);
                w.mask[t] = 1'b1;
              end else begin
                w.addr[t] = '0;
                w.mask[t] = 1'b0;
              end
            end
          w.ox = AW'(x);
          w.oy = AW'(y);
          w.c = AW'(ch);
          w.row = row;
          exp_q.push_back(w);
          n++;
        end
  endtask

  initial begin : ready_drv
    int phase;
    phase = 0;
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: i_ready = 1'b1;
        1: i_ready = 1'($urandom_range(0, 1));
        2: begin
          i_ready = (phase == 0 || phase == 3);
          phase = (phase + 1) % 4;
        end
        default: i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: mid-cycle sampling; a beat is accepted when valid and ready are both high.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (done_pending) begin
        check("done_pulse", 128'(o_done), 128'(1));
        if (o_done) done_seen++;
        done_pending = 1'b0;
      end else if (o_done) begin
        check("spurious_done", 128'(o_done), 128'(0));
      end
      if (o_valid) begin
        check("valid_done_excl", 128'(o_done), 128'(0));
        check("busy_while_valid", 128'(o_busy), 128'(1));
        if (stall_prev)
          check("stall_hold", 128'({o_addr, o_mask, o_o_x, o_o_y, o_c, o_row_id}), held);
        if (exp_q.size() == 0) begin
          check("unexpected_window", 128'(o_valid), 128'(0));
        end else begin
          mon_w = exp_q[0];
          check("win_addr", 128'(o_addr), 128'(mon_w.addr));
          check("win_mask", 128'(o_mask), 128'(mon_w.mask));
          check("win_xyc", 128'({o_o_x, o_o_y, o_c}), 128'({mon_w.ox, mon_w.oy, mon_w.c}));
          check("win_row", 128'(o_row_id), 128'(mon_w.row));
          if (i_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) done_pending = 1'b1;
          end
        end
        stall_prev = !i_ready;
        held = 128'({o_addr, o_mask, o_o_x, o_o_y, o_c, o_row_id});
      end else begin
        if (stall_prev) check("stall_valid_hold", 128'(o_valid), 128'(1));
        stall_prev = 1'b0;
      end
    end
  end

  task automatic run_case(input int st, input int ii, input int cc, input int ss, input int pp,
                          input logic [ROWS-1:0] row, input int rmode, output int n);
    ready_mode = rmode;
    @(posedge clk);
    #1;
    i_start_addr = AW'(st);
    i_i_size = AW'(ii);
    i_i_c_size = AW'(cc);
    i_stride = 2'(ss);
    i_pad = 2'(pp);
    i_row_id = row;
    i_start = 1'b1;
    model(st, ii, cc, ss, pp, row, n);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    // Scramble config after start; the design must have latched it.
    i_start_addr = AW'($urandom);
    i_i_size = AW'($urandom);
    i_i_c_size = AW'($urandom);
    i_stride = 2'($urandom);
    i_pad = 2'($urandom);
    i_row_id = ROWS'($urandom);
    if (n == 0) done_pending = 1'b1;
    @(negedge clk);
    check("first_valid", 128'(o_valid), 128'(n > 0));
  endtask

  task automatic wait_finish(input int target);
    int cyc;
    cyc = 0;
    while (done_seen < target && cyc < 4000) begin
      @(posedge clk);
      cyc++;
    end
    check("done_count", 128'(done_seen), 128'(target));
    check("drained", 128'(exp_q.size()), 128'(0));
    @(negedge clk);
  endtask

  initial begin
    int n, tgt;
    logic [0:TAPS-1][AW-1:0] c1_first, c2_first;
    c1_first = {6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd10};
    c2_first = {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd2, 6'd0, 6'd8, 6'd10};
    i_rst = 1'b1;
    i_clear = 1'b0;
    i_start = 1'b0;
    i_start_addr = '0;
    i_i_size = '0;
    i_i_c_size = '0;
    i_stride = '0;
    i_pad = '0;
    i_row_id = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 128'({o_valid, o_busy, o_done, o_addr, o_mask, o_o_x, o_o_y, o_c, o_row_id}), 128'(0));
    i_rst = 1'b0;

    // Basic 4x4, K=3, no pad.
    tgt = done_seen + 1;
    run_case(0, 4, 1, 1, 0, 4'b0001, 0, n);
    check("c1_first_addr", 128'(o_addr), 128'(c1_first));
    check("c1_first_mask", 128'(o_mask), 128'(9'h1FF));
    wait_finish(tgt);

    // Padding and two channels.
    tgt = done_seen + 1;
    run_case(0, 4, 2, 1, 1, 4'b0010, 1, n);
    check("c2_first_addr", 128'(o_addr), 128'(c2_first));
    check("c2_first_mask", 128'(o_mask), 128'(9'h1B0));
    wait_finish(tgt);

    // Stride 2 on a 5x5 map.
    tgt = done_seen + 1;
    run_case(0, 5, 1, 2, 0, 4'b0100, 0, n);
    wait_finish(tgt);

    // Backpressure pattern 1,0,0,1.
    tgt = done_seen + 1;
    run_case(0, 4, 1, 1, 0, 4'b1000, 2, n);
    wait_finish(tgt);

    // Empty work: map smaller than kernel, then zero channels.
    tgt = done_seen + 1;
    run_case(7, 2, 1, 1, 0, 4'b0001, 0, n);
    wait_finish(tgt);
    tgt = done_seen + 1;
    run_case(7, 4, 0, 1, 0, 4'b0001, 0, n);
    wait_finish(tgt);

    // Clear while a beat is stalled.
    run_case(5, 4, 2, 1, 1, 4'b0011, 3, n);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    i_clear = 1'b1;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    done_pending = 1'b0;
    @(negedge clk);
    check("clear_valid", 128'(o_valid), 128'(0));
    check("clear_busy", 128'(o_busy), 128'(0));
    check("clear_no_done", 128'(o_done), 128'(0));
    tgt = done_seen + 1;
    run_case(0, 4, 1, 1, 0, 4'b0101, 0, n);
    check("restart_xyc", 128'({o_o_x, o_o_y, o_c}), 128'(0));
    check("restart_addr", 128'(o_addr), 128'(c1_first));
    wait_finish(tgt);

    // Asynchronous reset mid-run.
    run_case(0, 4, 2, 1, 1, 4'b0110, 0, n);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    i_rst = 1'b1;
    exp_q.delete();
    stall_prev = 1'b0;
    done_pending = 1'b0;
    #1;
    check("async_reset", 128'({o_valid, o_busy, o_done, o_addr, o_mask, o_o_x, o_o_y, o_c, o_row_id}), 128'(0));
    @(posedge clk);
    #1;
    i_rst = 1'b0;

    // Randomised configurations with random backpressure.
    for (int r = 0; r < 8; r++) begin
      tgt = done_seen + 1;
      run_case(int'($urandom_range(0, 63)), int'($urandom_range(1, 8)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ROWS'($urandom), 1, n);
      wait_finish(tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
